// File: rtl/radix4_booth_seq_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix4_booth_pkg: shared types and constants for the radix-4 Booth   |
// | sequential multiplier.                                               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package radix4_booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit selects packed as {neg, one, two}
  localparam logic [2:0] ZERO = 3'b000;
  localparam logic [2:0] POS1 = 3'b010;
  localparam logic [2:0] POS2 = 3'b001;
  localparam logic [2:0] NEG1 = 3'b110;
  localparam logic [2:0] NEG2 = 3'b101;

  function automatic int booth_iters(input int n);
    return n / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_booth_seq_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix4_booth_seq_mult_if: operand/result valid-ready bus.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface radix4_booth_seq_mult_if #(
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] result;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/radix4_booth_seq_mult_booth_r4_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_r4_encoder: maps a multiplier bit triplet to {neg, one, two}.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module booth_r4_encoder
  import radix4_booth_pkg::*;
(
  input  logic [2:0] i_triplet,
  output logic       o_neg,
  output logic       o_one,
  output logic       o_two
);

  logic [2:0] w_sel;

  always_comb begin
    w_sel = ZERO;
    case (i_triplet)
      3'b001, 3'b010: w_sel = POS1;
      3'b011:         w_sel = POS2;
      3'b100:         w_sel = NEG2;
      3'b101, 3'b110: w_sel = NEG1;
      default:        w_sel = ZERO;
    endcase
  end

  assign {o_neg, o_one, o_two} = w_sel;

endmodule
`default_nettype wire

// File: rtl/radix4_booth_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix4_booth_seq_mult: iterative radix-4 Booth multiplier, 2 bits    |
// | per cycle, valid/ready in and out, signed or unsigned per operation. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module radix4_booth_seq_mult
  import radix4_booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  radix4_booth_seq_mult_if.slave bus
);

  localparam int              ITER     = booth_iters(N);
  localparam int              CNT_W    = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N+1:0]    a_q, a_d;
  logic [N+2:0]    hi_q, hi_d;
  logic [N+1:0]    lo_q, lo_d;
  logic            prev_q, prev_d;
  logic [2*N-1:0]  result_q, result_d;

  logic            w_neg, w_one, w_two;
  logic [N+2:0]    w_mag, w_addend, w_sum;

  booth_r4_encoder u_enc (
    .i_triplet ({lo_q[1:0], prev_q}),
    .o_neg     (w_neg),
    .o_one     (w_one),
    .o_two     (w_two)
  );

  // Upper half carries one guard bit so +/-2A never overflows the sum.
  always_comb begin
    w_mag = '0;
    if (w_one) begin
      w_mag = {a_q[N+1], a_q};
    end else if (w_two) begin
      w_mag = {a_q, 1'b0};
    end
    w_addend = w_neg ? (~w_mag + (N+3)'(1)) : w_mag;
    w_sum    = hi_q + w_addend;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prev_d   = prev_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_signed ? {{2{bus.in_a[N-1]}}, bus.in_a} : {2'b00, bus.in_a};
          lo_d    = bus.in_signed ? {{2{bus.in_b[N-1]}}, bus.in_b} : {2'b00, bus.in_b};
          hi_d    = '0;
          prev_d  = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Arithmetic shift right by 2 of {sum, multiplier}
        hi_d   = {{2{w_sum[N+2]}}, w_sum[N+2:2]};
        lo_d   = {w_sum[1:0], lo_q[N+1:2]};
        prev_d = lo_q[1];
        if (cnt_q == LAST_CNT) begin
          result_d = {w_sum[N-1:0], lo_q[N+1:2]};
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      prev_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      prev_q   <= prev_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;

endmodule
`default_nettype wire
